// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi decoder front end: accepts demapper symbols,
// feeds them to the bmu, appends flush tail symbols, waits for the bmu pipeline
// to drain, then starts and waits on traceback.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN     = 64,
  parameter int TAIL_LEN      = 2,
  parameter int DRAIN_TIMEOUT = 8,
  localparam int CW           = $clog2(FRAME_LEN + TAIL_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [1:0]    sym_data,
  input  logic          sym_last,
  output logic          bmu_refresh,
  output logic          bmu_valid_in,
  output logic [1:0]    bmu_bit_pair,
  input  logic          bmu_valid_out,
  output logic          tb_start,
  input  logic          tb_done,
  output logic          busy,
  output logic          frame_done,
  output logic [CW-1:0] sym_count,
  output logic          err_len,
  output logic          err_timeout
);

  // One down-counter is shared between the tail issue phase and the drain timeout.
  localparam int TMAX = (TAIL_LEN > DRAIN_TIMEOUT) ? TAIL_LEN : DRAIN_TIMEOUT;
  localparam int TW   = $clog2(TMAX);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_REFRESH | one-cycle bmu refresh
  // S_RUN     | accepting data symbols from the demapper
  // S_TAIL    | issuing 2'b00 flush symbols
  // S_DRAIN   | waiting for bmu results to come back (bounded)
  // S_TB      | traceback running
  // S_DONE    | one-cycle frame_done
  typedef enum logic [2:0] {
    S_IDLE, S_REFRESH, S_RUN, S_TAIL, S_DRAIN, S_TB, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count_nxt;
  logic [1:0]    pair_nxt;
  logic          vin_nxt, tb_start_nxt, err_len_nxt, err_to_nxt;
  logic          accept, final_sym;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    count_nxt    = sym_count;
    pair_nxt     = bmu_bit_pair;
    vin_nxt      = 1'b0;
    tb_start_nxt = 1'b0;
    err_len_nxt  = err_len;
    err_to_nxt   = err_timeout;
    accept       = sym_valid && sym_ready;
    // During RUN sym_count holds only data symbols, so this accept is number FRAME_LEN.
    final_sym    = (sym_count == CW'(FRAME_LEN - 1));
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_REFRESH;
          count_nxt   = '0;
          err_len_nxt = 1'b0;
          err_to_nxt  = 1'b0;
        end
      end
      S_REFRESH: state_nxt = S_RUN;
      S_RUN: begin
        if (accept) begin
          vin_nxt   = 1'b1;
          pair_nxt  = sym_data;
          count_nxt = sym_count + CW'(1);
          if (sym_last || final_sym) begin
            state_nxt = S_TAIL;
            timer_nxt = TW'(TAIL_LEN - 1);
            if (sym_last != final_sym) err_len_nxt = 1'b1;
          end
        end
      end
      S_TAIL: begin
        vin_nxt   = 1'b1;
        pair_nxt  = 2'b00;
        count_nxt = sym_count + CW'(1);
        if (timer == '0) begin
          state_nxt = S_DRAIN;
          timer_nxt = TW'(DRAIN_TIMEOUT - 1);
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_DRAIN: begin
        // The last tail symbol is still on bmu_valid_in in the first DRAIN cycle.
        if (outstanding == '0 && !bmu_valid_in) begin
          state_nxt    = S_TB;
          tb_start_nxt = 1'b1;
        end else if (timer == '0) begin
          state_nxt    = S_TB;
          tb_start_nxt = 1'b1;
          err_to_nxt   = 1'b1;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_TB:    if (tb_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      sym_ready    <= 1'b0;
      bmu_refresh  <= 1'b0;
      bmu_valid_in <= 1'b0;
      bmu_bit_pair <= 2'b00;
      tb_start     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      sym_count    <= '0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      sym_ready    <= (state_nxt == S_RUN);
      bmu_refresh  <= (state_nxt == S_REFRESH);
      bmu_valid_in <= vin_nxt;
      bmu_bit_pair <= pair_nxt;
      tb_start     <= tb_start_nxt;
      busy         <= (state_nxt != S_IDLE);
      frame_done   <= (state_nxt == S_DONE);
      sym_count    <= count_nxt;
      err_len      <= err_len_nxt;
      err_timeout  <= err_to_nxt;
    end
  end

  // Symbols in flight inside the bmu; saturates at zero on stray valid_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (state == S_IDLE && start) begin
      outstanding <= '0;
    end else if (bmu_valid_in && !bmu_valid_out) begin
      outstanding <= outstanding + CW'(1);
    end else if (!bmu_valid_in && bmu_valid_out && outstanding != '0) begin
      outstanding <= outstanding - CW'(1);
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: randomized symbol traffic, a bmu
// latency responder and a traceback responder, checked every cycle against a
// timestamp-based model of the frame sequence.
module tb_viterbi_frame_ctrl;
  localparam int FRAME_LEN = 64;
  localparam int TAIL_LEN  = 2;
  localparam int DRAIN_TO  = 8;
  localparam int CW        = $clog2(FRAME_LEN + TAIL_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, sym_valid = 1'b0, sym_last = 1'b0;
  logic [1:0]    sym_data = 2'b00;
  logic          sym_ready, bmu_refresh, bmu_valid_in, bmu_valid_out;
  logic [1:0]    bmu_bit_pair;
  logic          tb_start, tb_done = 1'b0, busy, frame_done, err_len, err_timeout;
  logic [CW-1:0] sym_count;

  viterbi_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .TAIL_LEN(TAIL_LEN), .DRAIN_TIMEOUT(DRAIN_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_data(sym_data), .sym_last(sym_last), .bmu_refresh(bmu_refresh),
    .bmu_valid_in(bmu_valid_in), .bmu_bit_pair(bmu_bit_pair), .bmu_valid_out(bmu_valid_out),
    .tb_start(tb_start), .tb_done(tb_done), .busy(busy), .frame_done(frame_done),
    .sym_count(sym_count), .err_len(err_len), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  task automatic check(string name, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // bmu responder: valid_out follows valid_in after lat cycles (lat=0: never)
  int lat = 1;
  logic [15:0] dl;
  always @(posedge clk or posedge rst)
    if (rst) dl <= '0;
    else     dl <= {dl[14:0], bmu_valid_in};
  assign bmu_valid_out = (lat > 0) ? dl[lat-1] : 1'b0;

  // traceback responder: tb_done pulses tbd_k cycles after tb_start
  int tbd_k = 1, tbd_wait = 0;
  initial forever begin
    @(posedge clk); #1;
    tb_done = 1'b0;
    if (rst) tbd_wait = 0;
    else if (tb_start) begin
      if (tbd_k == 0) tb_done = 1'b1;
      else tbd_wait = tbd_k;
    end else if (tbd_wait > 0) begin
      tbd_wait--;
      if (tbd_wait == 0) tb_done = 1'b1;
    end
  end

  // Reference model: frame events as cycle timestamps.
  // ts=start seen, tf=final data accept, T=tb_start cycle, F=frame_done cycle.
  int cyc = 0, ts = -1, tf = -1, T = -1, F = -1, acc_n = 0, cnt = 0, outst = 0;
  bit e_ready, e_refresh, e_vin, e_tbs, e_fd, e_busy, e_el, e_eto, p_acc;
  logic [1:0] e_pair, p_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ts = -1; tf = -1; T = -1; F = -1; acc_n = 0; cnt = 0; outst = 0; p_acc = 0;
      e_ready = 0; e_refresh = 0; e_vin = 0; e_tbs = 0; e_fd = 0; e_busy = 0;
      e_el = 0; e_eto = 0; e_pair = 2'b00;
    end else begin
      if (tf >= 0 && T < 0 && cyc >= tf + 1 + TAIL_LEN) begin
        if (outst == 0 && !e_vin) T = cyc + 1;
        else if (cyc == tf + TAIL_LEN + DRAIN_TO) begin T = cyc + 1; e_eto = 1; end
      end
      if (T >= 0 && F < 0 && cyc >= T && tb_done) F = cyc + 1;
      if (e_vin && !bmu_valid_out) outst++;
      else if (!e_vin && bmu_valid_out && outst > 0) outst--;
      p_acc  = e_ready && sym_valid;
      p_data = sym_data;
      if (p_acc) begin
        acc_n++;
        if (sym_last || acc_n == FRAME_LEN) begin
          tf   = cyc;
          e_el = (sym_last != (acc_n == FRAME_LEN));
        end
      end
      if (!e_busy && start) begin
        ts = cyc; tf = -1; T = -1; F = -1; acc_n = 0; cnt = 0; outst = 0; e_el = 0; e_eto = 0;
      end
      cyc++;
      e_refresh = (ts >= 0 && cyc == ts + 1);
      e_ready   = (ts >= 0 && cyc >= ts + 2 && tf < 0);
      e_vin     = p_acc || (tf >= 0 && cyc >= tf + 2 && cyc <= tf + 1 + TAIL_LEN);
      if (p_acc) e_pair = p_data;
      else if (e_vin) e_pair = 2'b00;
      if (e_vin) cnt++;
      e_tbs  = (T >= 0 && cyc == T);
      e_fd   = (F >= 0 && cyc == F);
      e_busy = (ts >= 0 && cyc >= ts + 1 && (F < 0 || cyc <= F));
    end
  end

  // Per-cycle comparison against the model, plus event counters for literal checks.
  int refresh_n = 0, vin_n = 0, tbs_n = 0, fd_n = 0, last_vin_cyc = 0, tbs_cyc = 0;
  always @(negedge clk) if (!rst) begin
    check("busy", busy, e_busy);
    check("sym_ready", sym_ready, e_ready);
    check("bmu_refresh", bmu_refresh, e_refresh);
    check("bmu_valid_in", bmu_valid_in, e_vin);
    check("bmu_bit_pair", bmu_bit_pair, e_pair);
    check("tb_start", tb_start, e_tbs);
    check("frame_done", frame_done, e_fd);
    check("sym_count", int'(sym_count), cnt);
    check("err_len", err_len, e_el);
    check("err_timeout", err_timeout, e_eto);
    refresh_n += bmu_refresh;
    vin_n     += bmu_valid_in;
    tbs_n     += tb_start;
    fd_n      += frame_done;
    if (bmu_valid_in) last_vin_cyc = cyc;
    if (tb_start)     tbs_cyc = cyc;
  end

  int b_ref, b_vin, b_tbs, b_fd;

  task automatic check_reset_state(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sym_ready"}, sym_ready, 0);
    check({tag, "_valid_in"}, bmu_valid_in, 0);
    check({tag, "_sym_count"}, int'(sym_count), 0);
    check({tag, "_errs"}, {err_len, err_timeout}, 0);
    check({tag, "_pulses"}, {bmu_refresh, tb_start, frame_done}, 0);
  endtask

  // One frame: start pulse, symbols offered with probability pct, optional abort
  // (async reset after abort_at accepts) and optional stray starts in RUN and TB.
  task automatic run_frame(int last_pos, int pct, int abort_at, bit glitch);
    int sent = 0, guard = 0, n_final;
    bit g_done = 0, got = 0;
    n_final = (last_pos < FRAME_LEN) ? last_pos : FRAME_LEN;
    b_ref = refresh_n; b_vin = vin_n; b_tbs = tbs_n; b_fd = fd_n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (sent < n_final && guard < 2000) begin
      start     = glitch && (sent == 5);
      sym_valid = ($urandom_range(99) < pct);
      sym_data  = 2'($urandom_range(3));
      sym_last  = (sent + 1 == last_pos);
      if (sym_valid && sym_ready) sent++;
      @(posedge clk); #1;
      guard++;
      if (abort_at > 0 && sent == abort_at) break;
    end
    sym_valid = 1'b0; sym_last = 1'b0; start = 1'b0;
    if (abort_at > 0) begin
      #1 rst = 1'b1;
      #1 check_reset_state("abort");
      @(posedge clk); #3 rst = 1'b0;
      return;
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; break; end
      if (glitch && tb_start && !g_done) begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        g_done = 1;
      end
    end
    check("frame_completed", got, 1);
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #3 rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    // 1: back-to-back, bmu latency 1
    lat = 1; tbd_k = 1;
    run_frame(64, 100, 0, 0);
    check("t1_sym_count", int'(sym_count), 66);
    check("t1_errs", {err_len, err_timeout}, 0);
    check("t1_refresh_pulses", refresh_n - b_ref, 1);
    check("t1_valid_in_count", vin_n - b_vin, 66);
    check("t1_tb_start_pulses", tbs_n - b_tbs, 1);
    check("t1_frame_done_pulses", fd_n - b_fd, 1);

    // 2: 50% valid, tb_done already high on the tb_start cycle
    lat = 2; tbd_k = 0;
    run_frame(64, 50, 0, 0);
    check("t2_sym_count", int'(sym_count), 66);
    check("t2_errs", {err_len, err_timeout}, 0);

    // 3: early sym_last on symbol 10
    lat = 1; tbd_k = 2;
    run_frame(10, 70, 0, 0);
    check("t3_sym_count", int'(sym_count), 12);
    check("t3_err_len", err_len, 1);
    check("t3_frame_done_pulses", fd_n - b_fd, 1);

    // 4: bmu never returns -> drain timeout
    lat = 0; tbd_k = 1;
    run_frame(64, 100, 0, 0);
    check("t4_err_timeout", err_timeout, 1);
    check("t4_tb_start_pulses", tbs_n - b_tbs, 1);
    check("t4_drain_cycles", tbs_cyc - last_vin_cyc, 8);

    // 5: reset during RUN after 20 symbols, then a clean frame
    lat = 3; tbd_k = 1;
    run_frame(64, 100, 20, 0);
    repeat (3) @(posedge clk); #1;
    run_frame(64, 100, 0, 0);
    check("t5_sym_count", int'(sym_count), 66);
    check("t5_errs", {err_len, err_timeout}, 0);

    // 6: stray starts in RUN and TB are ignored
    lat = 1; tbd_k = 3;
    run_frame(64, 80, 0, 1);
    check("t6_refresh_pulses", refresh_n - b_ref, 1);
    check("t6_frame_done_pulses", fd_n - b_fd, 1);
    check("t6_sym_count", int'(sym_count), 66);

    // randomized frames: mixed lengths, bmu latencies and traceback delays
    for (int f = 0; f < 5; f++) begin
      int sel, lp;
      sel = $urandom_range(2);
      lp  = (sel == 0) ? 64 : (sel == 1) ? $urandom_range(63, 2) : 70;
      lat   = $urandom_range(7);
      tbd_k = $urandom_range(3);
      run_frame(lp, $urandom_range(100, 30), 0, 0);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
